// File: rtl/pwm_dt_gen.sv
// pwm_dt_gen: complementary high/low PWM pair with programmable dead time and period-synchronous config update
module pwm_dt_gen #(
    parameter int W    = 48,
    parameter int DT_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [W-1:0]    cnt_i,
    input  logic            en,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic [W-1:0]    cfg_duty,
    input  logic [DT_W-1:0] cfg_dt,
    output logic            pwm_h,
    output logic            pwm_l,
    output logic            period_start,
    output logic            upd_done
);
    typedef enum logic [2:0] {IDLE, H_ON, DT_HL, L_ON, DT_LH} state_t;

    state_t          state_q, state_d;
    logic [DT_W-1:0] dt_cnt_q, dt_cnt_d;
    logic [W-1:0]    pend_duty_q, act_duty_q;
    logic [DT_W-1:0] pend_dt_q, act_dt_q;
    logic            pending_q, raw_q, period_start_q, upd_done_q;
    logic            boundary, take, apply, dt_zero;

    // A pending slot and a boundary update can never coincide: take needs !pending, apply needs pending.
    assign boundary  = cnt_i == '0;
    assign cfg_ready = !pending_q;
    assign take      = cfg_valid && cfg_ready;
    assign apply     = boundary && pending_q;
    assign dt_zero   = act_dt_q == '0;

    // Shadow capture on handshake, promotion to the active copy at a period boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q   <= 1'b0;
            pend_duty_q <= '0;
            pend_dt_q   <= '0;
            act_duty_q  <= '0;
            act_dt_q    <= '0;
        end else begin
            if (take) begin
                pending_q   <= 1'b1;
                pend_duty_q <= cfg_duty;
                pend_dt_q   <= cfg_dt;
            end else if (apply) begin
                pending_q <= 1'b0;
            end
            if (apply) begin
                act_duty_q <= pend_duty_q;
                act_dt_q   <= pend_dt_q;
            end
        end
    end

    // Registered compare and the one-cycle status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw_q          <= 1'b0;
            period_start_q <= 1'b0;
            upd_done_q     <= 1'b0;
        end else begin
            raw_q          <= cnt_i < act_duty_q;
            period_start_q <= en && boundary;
            upd_done_q     <= apply;
        end
    end

    // Dead-time FSM next state; a DT state with zero dead time is skipped entirely.
    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = raw_q ? (dt_zero ? H_ON : DT_LH) : (dt_zero ? L_ON : DT_HL);
                H_ON:    state_d = raw_q ? H_ON : (dt_zero ? L_ON : DT_HL);
                L_ON:    state_d = !raw_q ? L_ON : (dt_zero ? H_ON : DT_LH);
                DT_HL:   state_d = raw_q ? H_ON : (dt_cnt_q == DT_W'(1) ? L_ON : DT_HL);
                DT_LH:   state_d = !raw_q ? L_ON : (dt_cnt_q == DT_W'(1) ? H_ON : DT_LH);
                default: state_d = IDLE;
            endcase
        end
    end

    // Dead counter loads the active dead time on DT entry and counts down while the state holds.
    always_comb begin
        dt_cnt_d = '0;
        if (state_d == DT_HL || state_d == DT_LH)
            dt_cnt_d = (state_d != state_q) ? act_dt_q : dt_cnt_q - DT_W'(1);
    end

    // FSM state register; outputs decode directly from it so reset clears them asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            dt_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            dt_cnt_q <= dt_cnt_d;
        end
    end

    assign pwm_h        = state_q == H_ON;
    assign pwm_l        = state_q == L_ON;
    assign period_start = period_start_q;
    assign upd_done     = upd_done_q;
endmodule

// File: tb/tb_pwm_dt_gen.sv
// tb_pwm_dt_gen: table-driven and sequence checks of pwm_dt_gen fed by a STEP=2, CNT_MAX=16 counter
module tb_pwm_dt_gen;
    logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0, cfg_valid = 1'b0;
    logic [47:0] cnt_i = '0, cfg_duty = '0;
    logic [7:0]  cfg_dt = '0;
    logic        cfg_ready, pwm_h, pwm_l, period_start, upd_done;
    int          checks = 0, failures = 0;
    int          n_h, n_l, n_z, n_ps, n_upd, k;

    typedef struct {
        logic [47:0] duty;
        logic [7:0]  dt;
        int          h;
        int          l;
        int          z;
    } vec_t;
    vec_t vecs[8];
    vec_t sb[$];
    vec_t e;

    pwm_dt_gen #(.W(48), .DT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .cnt_i(cnt_i), .en(en),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_duty(cfg_duty), .cfg_dt(cfg_dt),
        .pwm_h(pwm_h), .pwm_l(pwm_l), .period_start(period_start), .upd_done(upd_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: sample just after the edge, then advance the upstream counter.
    task automatic cyc();
        @(posedge clk);
        #1;
        check("no_overlap", {63'd0, pwm_h && pwm_l}, 64'd0);
        n_h   += int'(pwm_h);
        n_l   += int'(pwm_l);
        n_z   += int'(!pwm_h && !pwm_l);
        n_ps  += int'(period_start);
        n_upd += int'(upd_done);
        cnt_i = (cnt_i == 48'd16) ? 48'd0 : cnt_i + 48'd2;
    endtask

    task automatic clr();
        n_h = 0; n_l = 0; n_z = 0; n_ps = 0; n_upd = 0;
    endtask

    task automatic wait_cnt(input logic [47:0] v);
        int i = 0;
        while (cnt_i != v && i < 20) begin cyc(); i++; end
        check("wait_cnt", 64'(cnt_i), 64'(v));
    endtask

    task automatic wait_upd();
        int i = 0;
        while (!upd_done && i < 30) begin cyc(); i++; end
        check("wait_upd", 64'(upd_done), 64'd1);
    endtask

    task automatic send(input logic [47:0] duty, input logic [7:0] dt);
        int i = 0;
        while (!cfg_ready && i < 40) begin cyc(); i++; end
        check("send_ready", 64'(cfg_ready), 64'd1);
        cfg_valid = 1'b1; cfg_duty = duty; cfg_dt = dt;
        cyc();
        cfg_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{48'd6,  8'd0, 3, 6, 0};
        vecs[1] = '{48'd6,  8'd2, 1, 4, 4};
        vecs[2] = '{48'd10, 8'd0, 5, 4, 0};
        vecs[3] = '{48'd10, 8'd1, 4, 3, 2};
        vecs[4] = '{48'd4,  8'd1, 1, 6, 2};
        vecs[5] = '{48'd0,  8'd2, 0, 9, 0};
        vecs[6] = '{48'd17, 8'd3, 9, 0, 0};
        vecs[7] = '{48'd2,  8'd3, 0, 8, 1};
        clr();
        repeat (3) cyc();
        check("rst_pwm_h", 64'(pwm_h), 64'd0);
        check("rst_pwm_l", 64'(pwm_l), 64'd0);
        check("rst_period_start", 64'(period_start), 64'd0);
        check("rst_upd_done", 64'(upd_done), 64'd0);
        check("rst_cfg_ready", 64'(cfg_ready), 64'd1);
        rst_n = 1'b1;
        repeat (4) cyc();
        check("idle_en0_h", 64'(pwm_h), 64'd0);
        check("idle_en0_l", 64'(pwm_l), 64'd0);
        en = 1'b1;
        // Steady-state per-period shape for each duty/dead-time pair.
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].duty, vecs[i].dt);
            sb.push_back(vecs[i]);
            repeat (30) cyc();
            clr();
            repeat (9) cyc();
            e = sb.pop_front();
            check($sformatf("v%0d_h", i), 64'(n_h), 64'(e.h));
            check($sformatf("v%0d_l", i), 64'(n_l), 64'(e.l));
            check($sformatf("v%0d_z", i), 64'(n_z), 64'(e.z));
            check($sformatf("v%0d_ps", i), 64'(n_ps), 64'd1);
        end
        // Latency: pwm_h rises two cycles after the cnt_i==0 cycle.
        send(48'd6, 8'd0);
        repeat (30) cyc();
        wait_cnt(48'd0);
        cyc();
        check("lat_ps", 64'(period_start), 64'd1);
        check("lat_h_early", 64'(pwm_h), 64'd0);
        cyc();
        check("lat_h", 64'(pwm_h), 64'd1);
        // Handshake at cnt_i=8 with a second request held while the slot is full.
        wait_cnt(48'd8);
        check("hs_ready", 64'(cfg_ready), 64'd1);
        cfg_valid = 1'b1; cfg_duty = 48'd10; cfg_dt = 8'd0;
        cyc();
        check("hs_busy", 64'(cfg_ready), 64'd0);
        cfg_duty = 48'd2;
        wait_upd();
        check("hs_upd_at_boundary", 64'(cnt_i), 64'd2);
        check("hs_ready_again", 64'(cfg_ready), 64'd1);
        clr();
        cyc();
        cfg_valid = 1'b0;
        check("hs_upd_one_cycle", 64'(upd_done), 64'd0);
        check("hs_second_taken", 64'(cfg_ready), 64'd0);
        repeat (8) cyc();
        check("hs_duty10_h", 64'(n_h), 64'd5);
        // Transfer during the cnt_i==0 cycle waits a whole period.
        wait_upd();
        wait_cnt(48'd0);
        check("b0_ready", 64'(cfg_ready), 64'd1);
        cfg_valid = 1'b1; cfg_duty = 48'd0; cfg_dt = 8'd0;
        cyc();
        cfg_valid = 1'b0;
        check("b0_no_upd", 64'(upd_done), 64'd0);
        k = 0;
        while (!upd_done && k < 30) begin cyc(); k++; end
        check("b0_upd_delay", 64'(k), 64'd9);
        repeat (20) cyc();
        clr();
        repeat (9) cyc();
        check("b0_duty0_l", 64'(n_l), 64'd9);
        // Enable drop while high, dead-time update while disabled, then re-enable.
        send(48'd17, 8'd0);
        repeat (30) cyc();
        check("en_h_steady", 64'(pwm_h), 64'd1);
        en = 1'b0;
        cyc();
        check("en_off_h", 64'(pwm_h), 64'd0);
        check("en_off_l", 64'(pwm_l), 64'd0);
        send(48'd17, 8'd3);
        wait_upd();
        clr();
        repeat (9) cyc();
        check("en_off_ps", 64'(n_ps), 64'd0);
        check("en_off_drive", 64'(n_h + n_l), 64'd0);
        en = 1'b1;
        clr();
        repeat (3) cyc();
        check("en_dt3_low", 64'(n_z), 64'd3);
        cyc();
        check("en_dt3_h", 64'(pwm_h), 64'd1);
        // Async reset in the middle of a dead time with a pending config.
        send(48'd6, 8'd3);
        repeat (30) cyc();
        k = 0;
        while ((pwm_h || pwm_l) && k < 20) begin cyc(); k++; end
        check("rd_in_dt", 64'(pwm_h || pwm_l), 64'd0);
        check("rd_ready", 64'(cfg_ready), 64'd1);
        cfg_valid = 1'b1; cfg_duty = 48'd17; cfg_dt = 8'd0;
        cyc();
        cfg_valid = 1'b0;
        check("rd_pending", 64'(cfg_ready), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        check("rd_async_h", 64'(pwm_h), 64'd0);
        check("rd_async_l", 64'(pwm_l), 64'd0);
        check("rd_async_ready", 64'(cfg_ready), 64'd1);
        repeat (2) cyc();
        rst_n = 1'b1;
        repeat (3) cyc();
        check("rd_l_on", 64'(pwm_l), 64'd1);
        clr();
        repeat (20) cyc();
        check("rd_no_upd", 64'(n_upd), 64'd0);
        check("rd_l_steady", 64'(n_l), 64'd20);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
